// File: rtl/key_debouncer.sv
// key_debouncer
//   Conditions active-low, bouncing, asynchronous pushbuttons into clean
//   signals in the CLOCK_50 domain. Each key gets a debounced level,
//   one-cycle press and release pulses, and contributes to a shared
//   wrapping press counter.
//
// Parameters
//   N_KEYS          number of pushbuttons (>= 1)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change (>= 2)
//   CNT_WIDTH       stability counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
//
// Ports
//   CLOCK_50     in   1       sole clock, rising edge
//   reset        in   1       asynchronous, active-high
//   KEY          in   N_KEYS  raw buttons, 0 = pressed
//   key_state    out  N_KEYS  debounced level, 1 = pressed
//   key_press    out  N_KEYS  one-cycle pulse per accepted press
//   key_release  out  N_KEYS  one-cycle pulse per accepted release
//   press_count  out  8       accepted presses across all keys, mod 256

module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [7:0]        press_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchronizer flops hold the raw (active-low) level; they reset to the
  // released value so a key held through reset is seen as a fresh press.
  logic [N_KEYS-1:0] sync_meta;
  logic [N_KEYS-1:0] sync_out;
  logic [N_KEYS-1:0] s;

  logic [N_KEYS-1:0][CNT_WIDTH-1:0] cnt;
  logic [N_KEYS-1:0][CNT_WIDTH-1:0] cnt_nxt;
  logic [N_KEYS-1:0]                state_nxt;
  logic [N_KEYS-1:0]                press_nxt;
  logic [N_KEYS-1:0]                release_nxt;
  logic [7:0]                       press_sum;

  assign s = ~sync_out;

  always_comb begin
    state_nxt   = key_state;
    press_nxt   = '0;
    release_nxt = '0;
    cnt_nxt     = cnt;
    press_sum   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (s[i] == key_state[i]) begin
        // any agreeing cycle throws away accumulated stability
        cnt_nxt[i] = '0;
      end else if (cnt[i] < CNT_LAST) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end else begin
        state_nxt[i]   = s[i];
        cnt_nxt[i]     = '0;
        press_nxt[i]   = s[i];
        release_nxt[i] = ~s[i];
      end
      press_sum = press_sum + {7'd0, press_nxt[i]};
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_meta   <= '1;
      sync_out    <= '1;
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      cnt         <= '0;
      press_count <= '0;
    end else begin
      sync_meta   <= KEY;
      sync_out    <= sync_meta;
      key_state   <= state_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      cnt         <= cnt_nxt;
      // counts on the same edge that registers the press pulses
      press_count <= press_count + press_sum;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Directed bench for key_debouncer with N_KEYS = 4, DEBOUNCE_CYCLES = 4.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_key_debouncer;

  logic       CLOCK_50;
  logic       reset;
  logic [3:0] KEY;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;

  key_debouncer #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .KEY(KEY),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .press_count(press_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] pr,
                         input logic [3:0] rl, input logic [7:0] cn);
    chk({tag, ".state"},   {4'd0, key_state},   {4'd0, st});
    chk({tag, ".press"},   {4'd0, key_press},   {4'd0, pr});
    chk({tag, ".release"}, {4'd0, key_release}, {4'd0, rl});
    chk({tag, ".count"},   press_count,         cn);
  endtask

  initial begin
    // 1. reset values
    KEY   = 4'b1111;
    reset = 1'b1;
    step(2);
    chk_all("reset", 4'h0, 4'h0, 4'h0, 8'd0);
    reset = 1'b0;
    step(20);
    chk_all("idle20", 4'h0, 4'h0, 4'h0, 8'd0);

    // 2. clean press and release on key 0
    KEY[0] = 1'b0;
    step(5);
    chk_all("k0_pre", 4'h0, 4'h0, 4'h0, 8'd0);
    step(1);
    chk_all("k0_press", 4'h1, 4'h1, 4'h0, 8'd1);
    step(1);
    chk_all("k0_held", 4'h1, 4'h0, 4'h0, 8'd1);
    KEY[0] = 1'b1;
    step(5);
    chk_all("k0_rel_pre", 4'h1, 4'h0, 4'h0, 8'd1);
    step(1);
    chk_all("k0_release", 4'h0, 4'h0, 4'h1, 8'd1);
    step(1);
    chk_all("k0_idle", 4'h0, 4'h0, 4'h0, 8'd1);

    // 3. bounce on key 1: never four stable cycles
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        KEY[1] = (p == 3);
        step(1);
        chk_all("bounce", 4'h0, 4'h0, 4'h0, 8'd1);
      end
    end
    KEY[1] = 1'b0;
    step(5);
    chk_all("k1_pre", 4'h0, 4'h0, 4'h0, 8'd1);
    step(1);
    chk_all("k1_press", 4'h2, 4'h2, 4'h0, 8'd2);
    KEY = 4'b1111;
    step(7);
    chk_all("k1_released", 4'h0, 4'h0, 4'h0, 8'd2);

    // 4. simultaneous presses from a fresh reset
    reset = 1'b1;
    #2;
    chk_all("reset2", 4'h0, 4'h0, 4'h0, 8'd0);
    reset = 1'b0;
    KEY   = 4'b0000;
    step(5);
    chk_all("all_pre", 4'h0, 4'h0, 4'h0, 8'd0);
    step(1);
    chk_all("all_press", 4'hF, 4'hF, 4'h0, 8'd4);
    KEY = 4'b1111;
    step(6);
    chk_all("all_release", 4'h0, 4'h0, 4'hF, 8'd4);

    // 5. wrap: 250 single presses bring the count to 254
    for (int n = 0; n < 250; n++) begin
      KEY = 4'b1110;
      step(6);
      KEY = 4'b1111;
      step(6);
    end
    chk_all("preload", 4'h0, 4'h0, 4'h1, 8'd254);
    KEY = 4'b1100;
    step(6);
    chk_all("wrap2", 4'h3, 4'h3, 4'h0, 8'd0);
    KEY = 4'b1111;
    step(6);
    KEY = 4'b0111;
    step(6);
    chk_all("wrap_plus1", 4'h8, 4'h8, 4'h0, 8'd1);
    KEY = 4'b1111;
    step(6);
    chk_all("k3_release", 4'h0, 4'h0, 4'h8, 8'd1);

    // 6. reset mid-debounce with key 2 held through reset
    KEY = 4'b1011;
    step(3);
    chk_all("k2_partial", 4'h0, 4'h0, 4'h0, 8'd1);
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'h0, 4'h0, 4'h0, 8'd0);
    step(2);
    chk_all("in_reset", 4'h0, 4'h0, 4'h0, 8'd0);
    reset = 1'b0;
    step(5);
    chk_all("k2_pre", 4'h0, 4'h0, 4'h0, 8'd0);
    step(1);
    chk_all("k2_press", 4'h4, 4'h4, 4'h0, 8'd1);
    step(1);
    chk_all("k2_held", 4'h4, 4'h0, 4'h0, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
